fft256_stream_ctrl: RTL and testbench

Sequencer between an upstream complex sample stream and the 256-point FFT core.
- Issues the core's frame START and gates its ED clock-enable from a valid/ready handshake.
- On request, pads zeros to drain the core pipeline.
- Re-frames core output into indexed 256-sample frames, suppressing samples that come only from padding.

---
 rtl/fft256_ctrl_pkg.sv | 19 +
 rtl/fft256_pos_ctr.sv | 18 +
 rtl/fft256_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_fft256_stream_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft256_ctrl_pkg.sv
// Shared types and widths for the 256-point FFT stream controller.
package fft256_ctrl_pkg;
  localparam int FRAME_LEN  = 256;
  localparam int FRAME_LOG2 = 8;
  localparam int FRM_W      = 16;
  localparam int DRN_W      = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STRT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    STRT  = S_STRT,
    RUN   = S_RUN,
    FLUSH = S_FLUSH
  } state_e;
endpackage

// File: rtl/fft256_pos_ctr.sv
// Frame position counter: clear, count enable, wrap pulse on the 255->0 step.
module fft256_pos_ctr
  import fft256_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  en,
  output logic [FRAME_LOG2-1:0] pos,
  output logic                  wrap
);
  assign wrap = en & (pos == FRAME_LOG2'(FRAME_LEN - 1));

  always_ff @(posedge CLK) begin
    if (RST || clr) pos <= '0;
    else if (en)    pos <= pos + 1'b1;
  end
endmodule

// File: rtl/fft256_stream_ctrl.sv
// Handshake-to-FFT-core sequencer: frame start, ED gating, zero-pad drain and
// output re-framing with padding-only frames suppressed.
module fft256_stream_ctrl
  import fft256_ctrl_pkg::*;
#(
  parameter int NB    = 12,
  parameter int DRAIN = 768
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  FLUSH_REQ,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [NB-1:0]         IN_DR,
  input  logic [NB-1:0]         IN_DI,
  output logic                  CORE_START,
  output logic                  CORE_ED,
  output logic [NB-1:0]         CORE_DR,
  output logic [NB-1:0]         CORE_DI,
  input  logic                  CORE_RDY,
  input  logic [NB-1:0]         CORE_DOR,
  input  logic [NB-1:0]         CORE_DOI,
  output logic                  OUT_VALID,
  output logic [NB-1:0]         OUT_DR,
  output logic [NB-1:0]         OUT_DI,
  output logic [FRAME_LOG2-1:0] OUT_IDX,
  output logic                  OUT_FIRST,
  output logic                  OUT_LAST,
  output logic [FRM_W-1:0]      FRAMES_IN,
  output logic [FRM_W-1:0]      FRAMES_OUT,
  output logic                  BUSY,
  output logic                  DONE
);
  state_e                state, state_nxt;
  logic                  stop, armed, ed_q;
  logic [DRN_W-1:0]      drain_cnt;
  logic [FRAME_LOG2-1:0] in_pos, out_pos;
  logic                  in_wrap, out_wrap;
  logic                  strt, run, accept, keep;
  logic                  stop_any, at_bound, drain_last;
  logic [FRM_W-1:0]      pending, pending_nxt;

  assign strt   = (state == STRT);
  assign run    = (state == RUN);
  assign accept = run & IN_VALID;

  fft256_pos_ctr u_in_pos (
    .CLK(CLK), .RST(RST), .clr(strt), .en(accept), .pos(in_pos), .wrap(in_wrap)
  );
  fft256_pos_ctr u_out_pos (
    .CLK(CLK), .RST(RST), .clr(strt), .en(keep), .pos(out_pos), .wrap(out_wrap)
  );

  // pending_nxt folds in a same-cycle input wrap so the last accept of a frame
  // already counts when deciding between FLUSH and IDLE.
  assign pending     = FRAMES_IN - FRAMES_OUT;
  assign pending_nxt = FRAMES_IN + {{(FRM_W-1){1'b0}}, in_wrap} - FRAMES_OUT;
  assign stop_any    = stop | FLUSH_REQ | ~EN;
  assign at_bound    = in_wrap | ((in_pos == '0) & ~accept);
  assign drain_last  = (drain_cnt == DRN_W'(DRAIN - 1));

  // Core output is only meaningful once RDY has been seen and it was clocked.
  assign keep = (armed | CORE_RDY) & ed_q & (pending != '0);

  assign IN_READY   = run;
  assign CORE_START = strt;
  assign BUSY       = (state != IDLE);

  always_comb begin
    CORE_ED = 1'b0;
    CORE_DR = '0;
    CORE_DI = '0;
    if (run) begin
      CORE_ED = IN_VALID;
      CORE_DR = IN_DR;
      CORE_DI = IN_DI;
    end else if (state == FLUSH) begin
      CORE_ED = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN) state_nxt = STRT;
      STRT:    state_nxt = RUN;
      RUN:     if (stop_any && at_bound) state_nxt = (pending_nxt != '0) ? FLUSH : IDLE;
      FLUSH:   if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      stop       <= 1'b0;
      armed      <= 1'b0;
      ed_q       <= 1'b0;
      drain_cnt  <= '0;
      FRAMES_IN  <= '0;
      FRAMES_OUT <= '0;
      DONE       <= 1'b0;
      OUT_VALID  <= 1'b0;
      OUT_DR     <= '0;
      OUT_DI     <= '0;
      OUT_IDX    <= '0;
      OUT_FIRST  <= 1'b0;
      OUT_LAST   <= 1'b0;
    end else begin
      state <= state_nxt;
      DONE  <= (state == FLUSH) & drain_last;
      ed_q  <= CORE_ED;

      // FLUSH_REQ is ignored in STRT; only a dropped EN is latched there.
      if (strt)     stop <= ~EN;
      else if (run) stop <= stop_any;
      else          stop <= 1'b0;

      if (state == FLUSH) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;

      if (strt)          armed <= 1'b0;
      else if (CORE_RDY) armed <= 1'b1;

      if (strt)         FRAMES_IN <= '0;
      else if (in_wrap) FRAMES_IN <= FRAMES_IN + 1'b1;

      if (strt)          FRAMES_OUT <= '0;
      else if (out_wrap) FRAMES_OUT <= FRAMES_OUT + 1'b1;

      OUT_VALID <= keep;
      OUT_FIRST <= keep & (out_pos == '0);
      OUT_LAST  <= out_wrap;
      if (keep) begin
        OUT_DR  <= CORE_DOR;
        OUT_DI  <= CORE_DOI;
        OUT_IDX <= out_pos;
      end
    end
  end
endmodule

// File: tb/tb_fft256_stream_ctrl.sv
// Directed bench for fft256_stream_ctrl with a delay-line FFT core stand-in.
module tb_fft256_stream_ctrl;
  localparam int NB    = 12;
  localparam int DRAIN = 257;

  logic CLK = 1'b0, RST = 1'b1, EN = 1'b0, FLUSH_REQ = 1'b0, IN_VALID = 1'b0;
  logic [NB-1:0] IN_DR = '0, IN_DI = '0;
  logic IN_READY, CORE_START, CORE_ED;
  logic [NB-1:0] CORE_DR, CORE_DI;
  logic CORE_RDY = 1'b0;
  logic [NB-1:0] CORE_DOR = '0, CORE_DOI = '0;
  logic OUT_VALID, OUT_FIRST, OUT_LAST, BUSY, DONE;
  logic [NB-1:0] OUT_DR, OUT_DI;
  logic [7:0] OUT_IDX;
  logic [15:0] FRAMES_IN, FRAMES_OUT;

  int tests = 0, fails = 0, acc = 0;
  int mon_n = 0, mon_bad = 0, consec = 0, n_start = 0;
  bit prev_v = 1'b0;

  fft256_stream_ctrl #(.NB(NB), .DRAIN(DRAIN)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FLUSH_REQ(FLUSH_REQ),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DR(IN_DR), .IN_DI(IN_DI),
    .CORE_START(CORE_START), .CORE_ED(CORE_ED), .CORE_DR(CORE_DR), .CORE_DI(CORE_DI),
    .CORE_RDY(CORE_RDY), .CORE_DOR(CORE_DOR), .CORE_DOI(CORE_DOI),
    .OUT_VALID(OUT_VALID), .OUT_DR(OUT_DR), .OUT_DI(OUT_DI), .OUT_IDX(OUT_IDX),
    .OUT_FIRST(OUT_FIRST), .OUT_LAST(OUT_LAST),
    .FRAMES_IN(FRAMES_IN), .FRAMES_OUT(FRAMES_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Core stand-in: RDY after the 256th ED, output = input of 255 EDs earlier.
  logic [NB-1:0] hr [0:2047];
  logic [NB-1:0] hi [0:2047];
  int ed_cnt = 0;
  always @(posedge CLK) begin
    CORE_RDY <= 1'b0;
    if (RST || CORE_START) ed_cnt = 0;
    else if (CORE_ED) begin
      hr[ed_cnt % 2048] = CORE_DR;
      hi[ed_cnt % 2048] = CORE_DI;
      if (ed_cnt >= 255) begin
        CORE_DOR <= hr[(ed_cnt - 255) % 2048];
        CORE_DOI <= hi[(ed_cnt - 255) % 2048];
      end
      if (ed_cnt == 255) CORE_RDY <= 1'b1;
      ed_cnt++;
    end
  end

  // Output monitor: sample n of a run must carry data n and index n mod 256.
  always @(negedge CLK) begin
    if (CORE_START) begin mon_n = 0; n_start++; end
    if (OUT_VALID) begin
      if (OUT_IDX !== 8'(mon_n) || OUT_DR !== 12'(mon_n) || OUT_DI !== ~12'(mon_n) ||
          OUT_FIRST !== (mon_n % 256 == 0) || OUT_LAST !== (mon_n % 256 == 255))
        mon_bad++;
      if (prev_v) consec++;
      mon_n++;
    end
    prev_v = OUT_VALID;
  end

  task automatic start_run();
    acc = 0; mon_bad = 0; consec = 0; n_start = 0;
    EN = 1'b1;
    @(negedge CLK);
    tests++;
    if (CORE_START !== 1'b1) begin fails++; $display("FAIL start_pulse got %b exp 1", CORE_START); end
    @(negedge CLK);
  endtask

  task automatic send(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      IN_VALID = 1'b1; IN_DR = 12'(acc); IN_DI = ~12'(acc);
      @(negedge CLK); acc++;
      if (gap) begin IN_VALID = 1'b0; @(negedge CLK); end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset_state();
    logic [95:0] v;
    v = {IN_READY, CORE_START, CORE_ED, CORE_DR, CORE_DI, OUT_VALID, OUT_DR, OUT_DI,
         OUT_IDX, OUT_FIRST, OUT_LAST, FRAMES_IN, FRAMES_OUT, BUSY, DONE};
    tests++;
    if (v !== '0) begin fails++; $display("FAIL reset_outputs got %h exp 0", v); end
  endtask

  task automatic test_flush512();
    int k;
    start_run();
    send(512, 1'b0);
    FLUSH_REQ = 1'b1;
    @(negedge CLK);
    FLUSH_REQ = 1'b0; EN = 1'b0;
    tests++;
    if ({IN_READY, CORE_ED} !== 2'b01) begin fails++; $display("FAIL f512_flush_entry got %b exp 01", {IN_READY, CORE_ED}); end
    wait_done(k);
    tests++;
    if (k != 257) begin fails++; $display("FAIL f512_done_delay got %0d exp 257", k); end
    tests++;
    if (FRAMES_IN !== 16'd2 || FRAMES_OUT !== 16'd2) begin fails++; $display("FAIL f512_frames got %0d/%0d exp 2/2", FRAMES_IN, FRAMES_OUT); end
    @(negedge CLK);
    tests++;
    if (mon_n != 512) begin fails++; $display("FAIL f512_out_count got %0d exp 512", mon_n); end
    tests++;
    if (mon_bad != 0) begin fails++; $display("FAIL f512_out_content got %0d bad exp 0", mon_bad); end
    tests++;
    if (n_start != 1) begin fails++; $display("FAIL f512_start_count got %0d exp 1", n_start); end
    tests++;
    if ({BUSY, DONE} !== 2'b00) begin fails++; $display("FAIL f512_idle got %b exp 00", {BUSY, DONE}); end
  endtask

  task automatic test_reset();
    start_run();
    send(100, 1'b0);
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL rst_in_run got %b exp 1", IN_READY); end
    RST = 1'b1; EN = 1'b0; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    test_reset_state();
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_toggle();
    int k;
    start_run();
    send(512, 1'b1);
    repeat (2) @(negedge CLK);
    tests++;
    if (mon_n != 257) begin fails++; $display("FAIL tog_out_count got %0d exp 257", mon_n); end
    tests++;
    if (consec != 0) begin fails++; $display("FAIL tog_gaps got %0d back-to-back exp 0", consec); end
    FLUSH_REQ = 1'b1;
    @(negedge CLK);
    FLUSH_REQ = 1'b0; EN = 1'b0;
    wait_done(k);
    @(negedge CLK);
    tests++;
    if (mon_n != 512 || FRAMES_OUT !== 16'd2) begin fails++; $display("FAIL tog_total got %0d/%0d exp 512/2", mon_n, FRAMES_OUT); end
    tests++;
    if (mon_bad != 0) begin fails++; $display("FAIL tog_content got %0d bad exp 0", mon_bad); end
  endtask

  task automatic test_partial();
    int k, cnt;
    start_run();
    send(37, 1'b0);
    FLUSH_REQ = 1'b1;
    @(negedge CLK);
    FLUSH_REQ = 1'b0; EN = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      IN_VALID = 1'b1; IN_DR = 12'(acc); IN_DI = ~12'(acc);
      if (IN_READY !== 1'b1) begin IN_VALID = 1'b0; break; end
      @(negedge CLK); acc++; cnt++;
    end
    IN_VALID = 1'b0;
    tests++;
    if (cnt != 219) begin fails++; $display("FAIL part_accepts got %0d exp 219", cnt); end
    tests++;
    if (CORE_ED !== 1'b1) begin fails++; $display("FAIL part_flushing got %b exp 1", CORE_ED); end
    wait_done(k);
    tests++;
    if (k != 257) begin fails++; $display("FAIL part_done_delay got %0d exp 257", k); end
    tests++;
    if (FRAMES_IN !== 16'd1 || FRAMES_OUT !== 16'd1 || mon_n != 256) begin
      fails++; $display("FAIL part_frames got %0d/%0d/%0d exp 1/1/256", FRAMES_IN, FRAMES_OUT, mon_n);
    end
    tests++;
    if (mon_bad != 0) begin fails++; $display("FAIL part_content got %0d bad exp 0", mon_bad); end
  endtask

  task automatic test_coincident();
    int k;
    start_run();
    send(255, 1'b0);
    IN_VALID = 1'b1; IN_DR = 12'(acc); IN_DI = ~12'(acc); FLUSH_REQ = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0; FLUSH_REQ = 1'b0;
    tests++;
    if ({IN_READY, CORE_ED} !== 2'b01) begin fails++; $display("FAIL coin_flush_next got %b exp 01", {IN_READY, CORE_ED}); end
    tests++;
    if (FRAMES_IN !== 16'd1) begin fails++; $display("FAIL coin_frames_in got %0d exp 1", FRAMES_IN); end
    wait_done(k);
    tests++;
    if (k != 257) begin fails++; $display("FAIL coin_done_delay got %0d exp 257", k); end
    @(negedge CLK);
    tests++;
    if (CORE_START !== 1'b1) begin fails++; $display("FAIL coin_restart got %b exp 1", CORE_START); end
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL coin_reidle got %b exp 0", BUSY); end
  endtask

  task automatic test_en_drop();
    int k;
    start_run();
    EN = 1'b0;
    @(negedge CLK);
    tests++;
    if ({BUSY, CORE_ED} !== 2'b00) begin fails++; $display("FAIL endrop_idle got %b exp 00", {BUSY, CORE_ED}); end
    wait_done(k);
    tests++;
    if (k != -1) begin fails++; $display("FAIL endrop_no_done got %0d exp -1", k); end
    tests++;
    if (FRAMES_IN !== 16'd0 || n_start != 1) begin fails++; $display("FAIL endrop_counts got %0d/%0d exp 0/1", FRAMES_IN, n_start); end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    test_reset_state();
    RST = 1'b0;
    @(negedge CLK);
    test_flush512();
    test_reset();
    test_toggle();
    test_partial();
    test_coincident();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
